// File: rtl/sfx_pkg.sv
// Shared SFX definitions: effect codes, issuer FSM states and the code-validity check.
package sfx_pkg;

  localparam logic [1:0] SFX_LASER = 2'b01;
  localparam logic [1:0] SFX_DEATH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sfxState_t;

  function automatic logic isValidCode(input logic [1:0] code);
    return (code == SFX_LASER) || (code == SFX_DEATH);
  endfunction

endpackage

// File: rtl/sfx_fifo.sv
// Small request queue with flush and a registered read port that doubles as the issue holding register.
module sfx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [1:0]               wrData,
  output logic [1:0]               rdData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wrPtrReg;
  logic [PW-1:0] rdPtrReg;
  logic [LW-1:0] levelReg;
  logic [1:0]    rdDataReg;
  logic          pushOk;
  logic          popOk;

  assign full   = (levelReg == LW'(DEPTH));
  assign empty  = (levelReg == '0);
  assign pushOk = push && !full;
  assign popOk  = pop && !empty;

  // A flush with push restarts the queue with the new entry in slot 0.
  always_ff @(posedge clk) begin
    if (pushOk) mem[flush ? '0 : wrPtrReg] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      wrPtrReg  <= '0;
      rdPtrReg  <= '0;
      levelReg  <= '0;
      rdDataReg <= 2'b00;
    end else begin
      if (popOk) rdDataReg <= mem[rdPtrReg];
      if (flush) begin
        rdPtrReg <= '0;
        wrPtrReg <= pushOk ? PW'(1) : '0;
        levelReg <= pushOk ? LW'(1) : '0;
      end else begin
        if (pushOk) wrPtrReg <= wrPtrReg + 1'b1;
        if (popOk)  rdPtrReg <= rdPtrReg + 1'b1;
        case ({pushOk, popOk})
          2'b10:   levelReg <= levelReg + 1'b1;
          2'b01:   levelReg <= levelReg - 1'b1;
          default: levelReg <= levelReg;
        endcase
      end
    end
  end

  assign rdData = rdDataReg;
  assign level  = levelReg;

endmodule

// File: rtl/sfx_request_issuer.sv
// Queues SFX requests and issues them one at a time to the sound register controller.
// Optional wait-for-done timeout is enabled by defining SFX_TIMEOUT_EN.
module sfx_request_issuer
  import sfx_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1 << 22
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   req_valid,
  input  logic [1:0]             req_code,
  output logic                   req_ready,
  output logic                   writeEn,
  output logic [1:0]             writeData,
  input  logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   timeout
);

  sfxState_t stateReg;
  sfxState_t stateNext;
  logic      full;
  logic      empty;
  logic      pushReq;
  logic      push;
  logic      flush;
  logic      pop;
  logic      overflowReg;
  logic      waitExpired;

  assign pushReq = req_valid && isValidCode(req_code);
  assign push    = pushReq && !full;
  assign flush   = push && (req_code == SFX_DEATH);

  sfx_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wrData(req_code),
    .rdData(writeData),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign req_ready = !full;

  always_ff @(posedge clk) begin
    if (!clr) begin
      stateReg    <= IDLE;
      overflowReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (pushReq && full) overflowReg <= 1'b1;
    end
  end

  assign overflow = overflowReg;

  always_comb begin
    stateNext = stateReg;
    pop       = 1'b0;
    writeEn   = 1'b0;
    busy      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        writeEn   = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (done || waitExpired) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef SFX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] waitCntReg;
  logic          timeoutReg;

  // Counter is 0 in the first WAIT cycle, so expiry lands after exactly TIMEOUT_CYCLES WAIT cycles.
  assign waitExpired = (waitCntReg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!clr) begin
      waitCntReg <= '0;
      timeoutReg <= 1'b0;
    end else begin
      waitCntReg <= (stateReg == WAIT) ? waitCntReg + 1'b1 : '0;
      if ((stateReg == WAIT) && !done && waitExpired) timeoutReg <= 1'b1;
    end
  end

  assign timeout = timeoutReg;
`else
  assign waitExpired = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_sfx_request_issuer.sv
// Directed bench for sfx_request_issuer; covers both builds (timeout scenario depends on SFX_TIMEOUT_EN).
module tb_sfx_request_issuer;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_valid;
  logic [1:0] req_code;
  logic       req_ready;
  logic       writeEn;
  logic [1:0] writeData;
  logic       done;
  logic       busy;
  logic [2:0] level;
  logic       overflow;
  logic       timeout;

  int nChecks = 0;
  int nFails  = 0;

  sfx_request_issuer #(
    .DEPTH         (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .req_valid(req_valid),
    .req_code (req_code),
    .req_ready(req_ready),
    .writeEn  (writeEn),
    .writeData(writeData),
    .done     (done),
    .busy     (busy),
    .level    (level),
    .overflow (overflow),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge one cycle after reset release; that cycle is cycle 0 of each test.
  task automatic doReset();
    clr = 1'b0; req_valid = 1'b0; req_code = 2'b00; done = 1'b0;
    tick(); tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    doReset();
    req_valid = 1'b1; req_code = 2'b01;
    tick(); tick();
    req_valid = 1'b0;
    clr = 1'b0;
    tick();
    nChecks++; if (level !== 3'd0) begin nFails++; $display("FAIL rst_level: got %0d want 0", level); end
    nChecks++; if (writeEn !== 1'b0) begin nFails++; $display("FAIL rst_writeEn: got %b want 0", writeEn); end
    nChecks++; if (writeData !== 2'b00) begin nFails++; $display("FAIL rst_writeData: got %b want 00", writeData); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL rst_busy: got %b want 0", busy); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    nChecks++; if (timeout !== 1'b0) begin nFails++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    clr = 1'b1;
    tick();
    nChecks++; if (req_ready !== 1'b1) begin nFails++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_laser();
    doReset();
    req_valid = 1'b1; req_code = 2'b01;
    nChecks++; if (writeEn !== 1'b0) begin nFails++; $display("FAIL laser_we_c0: got %b want 0", writeEn); end
    tick();
    req_valid = 1'b0;
    nChecks++; if (writeEn !== 1'b0) begin nFails++; $display("FAIL laser_we_c1: got %b want 0", writeEn); end
    nChecks++; if (level !== 3'd1) begin nFails++; $display("FAIL laser_level_c1: got %0d want 1", level); end
    tick();
    nChecks++; if (writeEn !== 1'b1) begin nFails++; $display("FAIL laser_we_c2: got %b want 1", writeEn); end
    nChecks++; if (writeData !== 2'b01) begin nFails++; $display("FAIL laser_data_c2: got %b want 01", writeData); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL laser_busy_c2: got %b want 0", busy); end
    tick();
    nChecks++; if (writeEn !== 1'b0) begin nFails++; $display("FAIL laser_we_c3: got %b want 0", writeEn); end
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL laser_busy_c3: got %b want 1", busy); end
    tick(); tick(); tick();
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL laser_busy_c6: got %b want 1", busy); end
    nChecks++; if (writeData !== 2'b01) begin nFails++; $display("FAIL laser_hold_c6: got %b want 01", writeData); end
    done = 1'b1;
    tick();
    done = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL laser_busy_c7: got %b want 0", busy); end
    tick();
    nChecks++; if (writeEn !== 1'b0) begin nFails++; $display("FAIL laser_we_c8: got %b want 0", writeEn); end
    $display("test_laser done");
  endtask

  task automatic test_overflow();
    doReset();
    req_valid = 1'b1; req_code = 2'b01;
    repeat (5) tick();
    // First laser went to the FSM, the next four fill the queue.
    nChecks++; if (level !== 3'd4) begin nFails++; $display("FAIL ovf_level_full: got %0d want 4", level); end
    nChecks++; if (req_ready !== 1'b0) begin nFails++; $display("FAIL ovf_ready: got %b want 0", req_ready); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL ovf_flag_pre: got %b want 0", overflow); end
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL ovf_busy: got %b want 1", busy); end
    tick();
    req_valid = 1'b0;
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_flag_post: got %b want 1", overflow); end
    nChecks++; if (level !== 3'd4) begin nFails++; $display("FAIL ovf_level_post: got %0d want 4", level); end
    tick();
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_death();
    doReset();
    req_valid = 1'b1; req_code = 2'b01;
    repeat (4) tick();
    nChecks++; if (level !== 3'd3) begin nFails++; $display("FAIL death_level_pre: got %0d want 3", level); end
    req_code = 2'b11;
    tick();
    req_valid = 1'b0;
    nChecks++; if (level !== 3'd1) begin nFails++; $display("FAIL death_level_post: got %0d want 1", level); end
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL death_busy: got %b want 1", busy); end
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    nChecks++; if (writeEn !== 1'b0) begin nFails++; $display("FAIL death_we_d1: got %b want 0", writeEn); end
    tick();
    nChecks++; if (writeEn !== 1'b1) begin nFails++; $display("FAIL death_we_d2: got %b want 1", writeEn); end
    nChecks++; if (writeData !== 2'b11) begin nFails++; $display("FAIL death_data_d2: got %b want 11", writeData); end
    nChecks++; if (level !== 3'd0) begin nFails++; $display("FAIL death_level_d2: got %0d want 0", level); end
    tick();
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL death_busy_d3: got %b want 1", busy); end
    $display("test_death done");
  endtask

  // Runs on from test_death: FSM in WAIT, queue empty, writeData = 11.
  task automatic test_invalid();
    int weSeen = 0;
    req_valid = 1'b1; req_code = 2'b00;
    tick();
    if (writeEn === 1'b1) weSeen++;
    req_code = 2'b10;
    tick();
    if (writeEn === 1'b1) weSeen++;
    req_valid = 1'b0;
    nChecks++; if (level !== 3'd0) begin nFails++; $display("FAIL inv_level: got %0d want 0", level); end
    nChecks++; if (weSeen !== 0) begin nFails++; $display("FAIL inv_writeEn: got %0d strobes want 0", weSeen); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL inv_overflow: got %b want 0", overflow); end
    nChecks++; if (writeData !== 2'b11) begin nFails++; $display("FAIL inv_hold: got %b want 11", writeData); end
    req_valid = 1'b1; req_code = 2'b01;
    repeat (4) tick();
    nChecks++; if (level !== 3'd4) begin nFails++; $display("FAIL inv_fill: got %0d want 4", level); end
    req_code = 2'b10;
    tick();
    req_code = 2'b00;
    tick();
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL inv_full_overflow: got %b want 0", overflow); end
    nChecks++; if (level !== 3'd4) begin nFails++; $display("FAIL inv_full_level: got %0d want 4", level); end
    req_code = 2'b01;
    tick();
    req_valid = 1'b0;
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL inv_valid_overflow: got %b want 1", overflow); end
    $display("test_invalid done");
  endtask

  task automatic test_reset_wait();
    int weSeen = 0;
    doReset();
    req_valid = 1'b1; req_code = 2'b01;
    repeat (3) tick();
    req_valid = 1'b0;
    nChecks++; if (level !== 3'd2) begin nFails++; $display("FAIL rw_level_pre: got %0d want 2", level); end
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL rw_busy_pre: got %b want 1", busy); end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    nChecks++; if (level !== 3'd0) begin nFails++; $display("FAIL rw_level: got %0d want 0", level); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL rw_busy: got %b want 0", busy); end
    nChecks++; if (writeData !== 2'b00) begin nFails++; $display("FAIL rw_data: got %b want 00", writeData); end
    nChecks++; if (req_ready !== 1'b1) begin nFails++; $display("FAIL rw_ready: got %b want 1", req_ready); end
    repeat (10) begin
      tick();
      if (writeEn === 1'b1) weSeen++;
    end
    nChecks++; if (weSeen !== 0) begin nFails++; $display("FAIL rw_no_write: got %0d strobes want 0", weSeen); end
    $display("test_reset_wait done");
  endtask

  task automatic test_wait_exit();
    int weSeen = 0;
    doReset();
    req_valid = 1'b1; req_code = 2'b01;
    tick(); tick();
    req_valid = 1'b0;
    nChecks++; if (writeEn !== 1'b1) begin nFails++; $display("FAIL wx_we_c2: got %b want 1", writeEn); end
`ifdef SFX_TIMEOUT_EN
    repeat (16) tick();
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL to_busy_c18: got %b want 1", busy); end
    nChecks++; if (timeout !== 1'b0) begin nFails++; $display("FAIL to_flag_c18: got %b want 0", timeout); end
    tick();
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL to_busy_c19: got %b want 0", busy); end
    nChecks++; if (timeout !== 1'b1) begin nFails++; $display("FAIL to_flag_c19: got %b want 1", timeout); end
    tick();
    nChecks++; if (writeEn !== 1'b1) begin nFails++; $display("FAIL to_reissue_c20: got %b want 1", writeEn); end
    nChecks++; if (writeData !== 2'b01) begin nFails++; $display("FAIL to_data_c20: got %b want 01", writeData); end
    tick();
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL to_busy_c21: got %b want 1", busy); end
`else
    repeat (58) begin
      tick();
      if (writeEn === 1'b1) weSeen++;
    end
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL nto_busy: got %b want 1", busy); end
    nChecks++; if (timeout !== 1'b0) begin nFails++; $display("FAIL nto_flag: got %b want 0", timeout); end
    nChecks++; if (level !== 3'd1) begin nFails++; $display("FAIL nto_level: got %0d want 1", level); end
`endif
    nChecks++; if (weSeen !== 0) begin nFails++; $display("FAIL wx_stray_write: got %0d strobes want 0", weSeen); end
    $display("test_wait_exit done");
  endtask

  initial begin
    clr = 1'b0; req_valid = 1'b0; req_code = 2'b00; done = 1'b0;
    test_reset();
    test_laser();
    test_overflow();
    test_death();
    test_invalid();
    test_reset_wait();
    test_wait_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sfx_request_issuer.md
SFX_REQUEST_ISSUER -- requirements
Module: sfx_request_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queued request capacity (power of two, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2^22, meaning the maximum wait for done before abandoning a request.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the game logic presents an SFX request.
REQ-006 The block SHALL have port req_code, input, 2 bits: the SFX code (2'b01 laser, 2'b11 death; 2'b00 and 2'b10 are invalid).
REQ-007 The block SHALL have port req_ready, output, 1 bit: the queue can accept a request.
REQ-008 The block SHALL have port writeEn, output, 1 bit: a one-cycle write strobe to the sound register controller.
REQ-009 The block SHALL have port writeData, output, 2 bits: the SFX code written with writeEn.
REQ-010 The block SHALL have port done, input, 1 bit: a one-cycle pulse from the SFX FSM marking the current effect finished.
REQ-011 The block SHALL have port busy, output, 1 bit: an issued request is awaiting done.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: the number of queued entries.
REQ-013 The block SHALL have port overflow, output, 1 bit: a sticky flag set when a valid request is dropped.
REQ-014 The block SHALL have port timeout, output, 1 bit: a sticky flag set when a wait for done expires.

Function
REQ-015 The request SHALL be accepted when req_valid && req_ready && the code is valid; req_ready = !full, registered, and a same-cycle pop SHALL NOT admit a push while full.
REQ-016 A valid request presented while full SHALL be dropped and SHALL set overflow; invalid codes SHALL be discarded silently without affecting any state.
REQ-017 An accepted death request SHALL flush every queued entry and then enqueue itself (level becomes 1); this SHALL NOT affect a request already issued.
REQ-018 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-019 In IDLE with level greater than 0, the FSM SHALL pop the head entry into a holding register and move to ISSUE.
REQ-020 In ISSUE, writeEn SHALL be 1 for exactly one cycle with writeData set to the held code, and the FSM SHALL then move to WAIT.
REQ-021 In WAIT, busy SHALL be 1; on done the FSM SHALL return to IDLE, and done SHALL be ignored in IDLE and ISSUE.
REQ-022 Latency: a request accepted in cycle 0 with an empty queue and the FSM in IDLE SHALL produce writeEn in cycle 2.
REQ-023 The next request SHALL NOT be issued earlier than the second cycle after done.
REQ-024 writeData SHALL hold its last value when writeEn is 0.
REQ-025 The level counter SHALL NOT wrap, and the pointers SHALL wrap modulo DEPTH.
REQ-026 Simultaneous push and pop when not full SHALL leave level unchanged.

Reset
REQ-027 When clr is 0 at a clock edge, the block SHALL set FSM=IDLE, pointers=0, level=0, writeEn=0, writeData=2'b00, busy=0, overflow=0, timeout=0, and req_ready SHALL read 1 the cycle after reset is released.
REQ-028 Reset mid-WAIT SHALL abandon the issued request without emitting any write.

Configuration
REQ-029 The macro SFX_TIMEOUT_EN SHALL control the timeout feature.
REQ-030 With SFX_TIMEOUT_EN defined, a WAIT counter SHALL start at 0 on entry to WAIT; if done has not arrived after TIMEOUT_CYCLES cycles, the FSM SHALL go to IDLE and set timeout.
REQ-031 Without SFX_TIMEOUT_EN, there SHALL be no counter, WAIT SHALL exit only on done, and timeout SHALL be constant 0.

Structure
REQ-032 Package sfx_pkg SHALL hold the SFX code constants (SFX_LASER, SFX_DEATH), the FSM state type, and a code-validity function.
REQ-033 The queue SHALL be a sub-module sfx_fifo (push, pop, flush, level, full, empty); the FSM and the timeout SHALL remain in the top module.

Verification
REQ-034 Reset, then a laser request in cycle 0 -> writeEn=1 and writeData=01 in cycle 2 only; busy=1 from cycle 3 until the cycle after done.
REQ-035 Five laser requests back-to-back with DEPTH=4 and done withheld -> the first is issued, four are queued, req_ready=0, the fifth request sets overflow=1, and level=4.
REQ-036 Three lasers queued, then a death request -> level=1, and the next issue after done carries writeData=11.
REQ-037 req_code=00 and 10 presented -> level, writeEn and flags unchanged.
REQ-038 With SFX_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done -> the FSM is in IDLE after 16 WAIT cycles, timeout=1, and the next queued entry is issued; without the macro, busy stays 1 indefinitely.
REQ-039 clr=0 during WAIT with two entries queued -> all outputs are at reset values the next cycle and no writeEn occurs afterward.
